alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, width-parametrised successor of the lab ALU. It registers every result and adds a valid/ready handshake on the operand side. It adds an iterative unsigned multiplier/divider that takes WIDTH cycles, in place of the combinational mul/div path. The block sits between the decode/operand-fetch stage and writeback, which stalls on `o_ready`.

## Interface
- `WIDTH`, 32: operand/result width; power of two, 8..64.
- `SHW` (localparam), `$clog2(WIDTH)`: shift-amount width.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  operands/opcode present.
- `o_ready`  out  1  block can accept an operation this cycle.
- `i_a`  in  WIDTH  operand A.
- `i_b`  in  WIDTH  operand B (shift amount = `i_b[SHW-1:0]`).
- `i_alufunc`  in  2  group: 00 logic, 10 shift, 01 mul/div, 11 add/sub.
- `i_opt`  in  3  operation within group.
- `o_valid`  out  1  one-cycle pulse, result and flags valid.
- `o_result`  out  WIDTH  registered result, held until next `o_valid`.
- `o_zero`  out  1  result == 0.
- `o_ovfl`  out  1  signed overflow (ADD/SUB only).
- `o_divz`  out  1  divide by zero (DIVU/REMU only).

## Operation
- Accept: `i_valid & o_ready` at a rising edge. Opcode and operands are captured; inputs are don't-care afterwards.
- Logic `i_opt[1:0]`: 00 AND, 01 OR, 10 XOR, 11 NOR.
- Shift `i_opt`:
  - 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR.
  - 101..111 pass `i_a`.
  - Amount 0 returns `i_a`.
- Add/sub `i_opt[1:0]`:
  - 00 ADD, 01 SUB (both modulo 2^WIDTH).
  - 10 SLT signed, 11 SLTU. SLT/SLTU return 1 or 0, zero-extended.
  - `o_ovfl`: ADD when same-sign operands give an opposite-sign result. SUB when opposite-sign operands give a result whose sign differs from A. 0 for all other ops.
- Mul/div `i_opt[1:0]`, all unsigned:
  - 00 MUL: low WIDTH bits of the product. 01 MULHU: high WIDTH bits.
  - MUL/MULHU use a shift-add over a 2*WIDTH accumulator.
  - 10 DIVU: quotient. 11 REMU: remainder. Both use a restoring divider.
- Divide by zero: DIVU returns all ones; REMU returns `i_a`. `o_divz`=1 and the operation still takes full latency.
- FSM states:
  - IDLE: `o_ready`=1. Accepting a single-cycle op stays in IDLE. Accepting a mul/div op goes to MUL or DIV, with the iteration counter loaded with WIDTH-1.
  - MUL / DIV: `o_ready`=0. One iteration per cycle. The counter decrements.
  - The counter==0 iteration writes `o_result` and flags, pulses `o_valid`, and returns to IDLE.
- `o_zero` is computed from the value written to `o_result`. `o_zero`, `o_ovfl` and `o_divz` update only with `o_valid`.
- No output backpressure: the consumer must take the result on the `o_valid` cycle.

## Timing
- Reset values:
  - `o_valid`=0, `o_result`=0, `o_zero`=0, `o_ovfl`=0, `o_divz`=0.
  - FSM=IDLE and counter=0.
  - `o_ready`=0 while `i_rst` is high and 1 in the first cycle after release.
- Single-cycle ops: accepted at edge N, so `o_valid`=1 in the cycle after N. Throughput is one op per cycle back-to-back.
- Mul/div ops: accepted at edge N, so `o_valid`=1 after edge N+WIDTH (WIDTH cycles of `o_ready`=0, ending on the `o_valid` cycle).
- `o_ready` returns to 1 in the same cycle `o_valid` pulses. A new op may be accepted on that edge.
- `i_valid` while `o_ready`=0 is ignored; the upstream stage must hold its request.
- Reset mid-operation aborts the iteration. The partial result is never presented and no `o_valid` is produced.
- `o_valid` is never high for two consecutive cycles from one op.

## Configuration
- `ALU_MULDIV_EN` defined: the iterative multiplier/divider, MUL/DIV states and counter are built as described.
- Undefined: no mul/div hardware. Group 01 is treated as single-cycle:
  - `o_result`=0, `o_zero`=1, `o_divz`=0.
  - `o_valid` is asserted one cycle after acceptance and `o_ready` never drops.

## Test plan
WIDTH=32, `ALU_MULDIV_EN` defined unless stated.
- Reset, then ADD 0x7FFFFFFF+1 → `o_valid` next cycle, `o_result`=0x80000000, `o_ovfl`=1, `o_zero`=0. Follow with SUB 5-5 back-to-back → 0, `o_zero`=1, `o_ovfl`=0.
- SRA 0x80000010 by 4 → 0xF8000001. ROR 0x00000001 by 1 → 0x80000000. SLL by 0 → `i_a` unchanged. SLT 0xFFFFFFFF,1 → 1; SLTU on the same operands → 0.
- MUL 0xFFFFFFFF×0xFFFFFFFF → `o_ready` low for 32 cycles, `o_valid` after edge N+32, 0x00000001. MULHU on the same operands → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 9/0 → 0xFFFFFFFF with `o_divz`=1; REMU 9/0 → 9.
- Assert `i_rst` 10 cycles into a DIVU → no `o_valid`, all outputs 0. ADD 2+3 issued in the first cycle after reset is accepted → 5.
- `ALU_MULDIV_EN` undefined: MUL 3×4 → `o_valid` next cycle, `o_result`=0, `o_zero`=1, `o_ready` stays 1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result bundle between the operand-fetch stage and alu_mc.
//   master : upstream driver (i_valid, i_a, i_b, i_alufunc, i_opt; sees o_*)
//   slave  : the ALU (consumes i_*, drives o_ready, o_valid, o_result and flags)
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [1:0]       i_alufunc;
  logic [2:0]       i_opt;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_zero;
  logic             o_ovfl;
  logic             o_divz;

  modport master (
    output i_valid, i_a, i_b, i_alufunc, i_opt,
    input  o_ready, o_valid, o_result, o_zero, o_ovfl, o_divz
  );

  modport slave (
    input  i_valid, i_a, i_b, i_alufunc, i_opt,
    output o_ready, o_valid, o_result, o_zero, o_ovfl, o_divz
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/flags and a valid/ready
// handshake on the operand side.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_valid/o_ready accept handshake, i_a/i_b operands,
//                  i_alufunc group + i_opt operation, o_valid pulse with
//                  o_result, o_zero, o_ovfl, o_divz.
// Build option: define ALU_MULDIV_EN to build the iterative unsigned
// multiplier/divider (WIDTH cycles). Without it, group 01 completes in one
// cycle with a zero result.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic     i_clk,
  input logic     i_rst,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] GRP_LOGIC  = 2'b00;
  localparam logic [1:0] GRP_MULDIV = 2'b01;
  localparam logic [1:0] GRP_SHIFT  = 2'b10;
  localparam logic [1:0] GRP_ADDSUB = 2'b11;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovfl_q, ovfl_d;
  logic             divz_q, divz_d;

  logic             accept_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_ovfl_s;
  logic [SHW-1:0]   amt_s;
  logic [SHW:0]     rsh_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;

  assign accept_s = bus.i_valid && bus.o_ready;

  // Single-cycle datapath: logic, shift and add/sub results from the live inputs.
  always_comb begin
    amt_s     = bus.i_b[SHW-1:0];
    // Complementary shift for rotates; an amount of WIDTH shifts everything out.
    rsh_s     = (SHW+1)'(WIDTH) - {1'b0, amt_s};
    sum_s     = bus.i_a + bus.i_b;
    diff_s    = bus.i_a - bus.i_b;
    sc_res_s  = {WIDTH{1'b0}};
    sc_ovfl_s = 1'b0;
    case (bus.i_alufunc)
      GRP_LOGIC: begin
        case (bus.i_opt[1:0])
          2'b00:   sc_res_s = bus.i_a & bus.i_b;
          2'b01:   sc_res_s = bus.i_a | bus.i_b;
          2'b10:   sc_res_s = bus.i_a ^ bus.i_b;
          default: sc_res_s = ~(bus.i_a | bus.i_b);
        endcase
      end
      GRP_SHIFT: begin
        case (bus.i_opt)
          3'b000:  sc_res_s = bus.i_a << amt_s;
          3'b001:  sc_res_s = bus.i_a >> amt_s;
          3'b010:  sc_res_s = $unsigned($signed(bus.i_a) >>> amt_s);
          3'b011:  sc_res_s = (bus.i_a << amt_s) | (bus.i_a >> rsh_s);
          3'b100:  sc_res_s = (bus.i_a >> amt_s) | (bus.i_a << rsh_s);
          default: sc_res_s = bus.i_a;
        endcase
      end
      GRP_ADDSUB: begin
        case (bus.i_opt[1:0])
          2'b00: begin
            sc_res_s  = sum_s;
            sc_ovfl_s = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) &&
                        (sum_s[WIDTH-1] != bus.i_a[WIDTH-1]);
          end
          2'b01: begin
            sc_res_s  = diff_s;
            sc_ovfl_s = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1]) &&
                        (diff_s[WIDTH-1] != bus.i_a[WIDTH-1]);
          end
          2'b10:   sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
          default: sc_res_s = {{(WIDTH-1){1'b0}}, (bus.i_a < bus.i_b)};
        endcase
      end
      default: sc_res_s = {WIDTH{1'b0}};  // group 01: iterative unit or zero stub
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               sel_q, sel_d;          // 1: MULHU / REMU (upper half of acc)
  logic [WIDTH-1:0]   opnd_q, opnd_d;        // multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;          // {hi, lo}: {product hi, multiplier} or {remainder, quotient}
  logic               divz_pend_q, divz_pend_d;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] acc_step_s;

  assign bus.o_ready = (state_q == ST_IDLE) && !i_rst;

  // One shift-add or restoring-divide iteration on the accumulator.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_q;
    if (state_q == ST_MUL) begin
      acc_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end else if (div_shift_s >= {1'b0, opnd_q}) begin
      acc_step_s = {div_diff_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state: accept, iterate, and publish results with a one-cycle o_valid.
  always_comb begin
    valid_d     = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    ovfl_d      = ovfl_q;
    divz_d      = divz_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    divz_pend_d = divz_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (bus.i_alufunc == GRP_MULDIV)) begin
          state_d     = bus.i_opt[1] ? ST_DIV : ST_MUL;
          cnt_d       = SHW'(WIDTH - 1);
          sel_d       = bus.i_opt[0];
          opnd_d      = bus.i_opt[1] ? bus.i_b : bus.i_a;
          acc_d       = {{WIDTH{1'b0}}, (bus.i_opt[1] ? bus.i_a : bus.i_b)};
          divz_pend_d = bus.i_opt[1] && (bus.i_b == {WIDTH{1'b0}});
        end else if (accept_s) begin
          valid_d  = 1'b1;
          result_d = sc_res_s;
          zero_d   = (sc_res_s == {WIDTH{1'b0}});
          ovfl_d   = sc_ovfl_s;
          divz_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = acc_step_s;
        if (cnt_q == {SHW{1'b0}}) begin
          // A zero divisor naturally yields all-ones quotient and remainder = A.
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          result_d = sel_q ? acc_step_s[2*WIDTH-1:WIDTH] : acc_step_s[WIDTH-1:0];
          zero_d   = (result_d == {WIDTH{1'b0}});
          ovfl_d   = 1'b0;
          divz_d   = divz_pend_q;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iterative-unit state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {SHW{1'b0}};
      sel_q       <= 1'b0;
      opnd_q      <= {WIDTH{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      divz_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      divz_pend_q <= divz_pend_d;
    end
  end
`else
  assign bus.o_ready = !i_rst;

  // Next-state: every accepted op completes in one cycle.
  always_comb begin
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovfl_d   = ovfl_q;
    divz_d   = divz_q;
    if (accept_s) begin
      valid_d  = 1'b1;
      result_d = sc_res_s;
      zero_d   = (sc_res_s == {WIDTH{1'b0}});
      ovfl_d   = sc_ovfl_s;
      divz_d   = 1'b0;
    end else begin
      valid_d = 1'b0;
    end
  end
`endif

  // Result and flag registers; flags change only together with o_valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovfl_q   <= ovfl_d;
      divz_q   <= divz_d;
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_zero   = zero_q;
  assign bus.o_ovfl   = ovfl_q;
  assign bus.o_divz   = divz_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed + randomized self-checking bench for alu_mc (WIDTH=32).
// Expected values come from an arithmetic reference model of the operation set.
module tb_alu_mc;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: result, overflow, divide-by-zero and edges-to-valid.
  function automatic void model(input logic [1:0] f, input logic [2:0] o,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov,
                                output logic dz, output int lat);
    longint      sa, sb, s;
    logic [63:0] p;
    int          amt;
    r = '0; ov = 1'b0; dz = 1'b0; lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = int'(b % W);
    case (f)
      2'b00: case (o[1:0])
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: r = a ^ b;
        default: r = ~(a | b);
      endcase
      2'b10: begin
        p = {a, a};
        case (o)
          3'd0: r = a << amt;
          3'd1: r = a >> amt;
          3'd2: r = $signed(a) >>> amt;
          3'd3: begin p = p << amt; r = p[63:32]; end
          3'd4: begin p = p >> amt; r = p[31:0]; end
          default: r = a;
        endcase
      end
      2'b11: case (o[1:0])
        2'b00: begin s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        2'b01: begin s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        2'b10: r = (sa < sb) ? 32'd1 : 32'd0;
        default: r = (a < b) ? 32'd1 : 32'd0;
      endcase
      default: begin
`ifdef ALU_MULDIV_EN
        lat = W;
        p = {32'd0, a} * {32'd0, b};
        case (o[1:0])
          2'b00: r = p[31:0];
          2'b01: r = p[63:32];
          2'b10: begin dz = (b == 0); r = dz ? 32'hFFFF_FFFF : a / b; end
          default: begin dz = (b == 0); r = dz ? a : a % b; end
        endcase
`else
        r = '0;
`endif
      end
    endcase
  endfunction

  // Issue one op, wait (bounded) for o_valid, and check everything against the model.
  task automatic do_op(input string tag, input logic [1:0] f, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit use_spec, input logic [W-1:0] spec_r);
    logic [W-1:0] er;
    logic         eov, edz;
    int           elat, lat, low, n;
    model(f, o, a, b, er, eov, edz, elat);
    n = 0;
    while (bus.o_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, ".ready_in"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1; bus.i_alufunc = f; bus.i_opt = o; bus.i_a = a; bus.i_b = b;
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_a = $urandom; bus.i_b = $urandom;
    bus.i_alufunc = 2'($urandom); bus.i_opt = 3'($urandom);
    lat = 0; low = 0;
    while (bus.o_valid !== 1'b1 && lat < 200) begin
      if (bus.o_ready === 1'b0) low++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".ready_low"}, 64'(low), 64'(elat));
    chk({tag, ".ready_out"}, 64'(bus.o_ready), 64'd1);
    chk({tag, ".result"}, 64'(bus.o_result), 64'(er));
    chk({tag, ".zero"}, 64'(bus.o_zero), 64'(er == '0));
    chk({tag, ".ovfl"}, 64'(bus.o_ovfl), 64'(eov));
    chk({tag, ".divz"}, 64'(bus.o_divz), 64'(edz));
    if (use_spec) chk({tag, ".spec"}, 64'(bus.o_result), 64'(spec_r));
  endtask

  initial begin
    logic [1:0]   rf;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    tests = 0; fails = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_alufunc = 2'b00; bus.i_opt = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(bus.o_valid), 64'd0);
    chk("rst.result", 64'(bus.o_result), 64'd0);
    chk("rst.flags", 64'({bus.o_zero, bus.o_ovfl, bus.o_divz}), 64'd0);
    chk("rst.ready", 64'(bus.o_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ready_release", 64'(bus.o_ready), 64'd1);

    do_op("add_ovf", 2'b11, 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000);
    do_op("sub_zero", 2'b11, 3'b001, 32'd5, 32'd5, 1'b1, 32'h0);
    do_op("sra", 2'b10, 3'b010, 32'h8000_0010, 32'd4, 1'b1, 32'hF800_0001);
    do_op("ror", 2'b10, 3'b100, 32'h0000_0001, 32'd1, 1'b1, 32'h8000_0000);
    do_op("rol", 2'b10, 3'b011, 32'h8000_0001, 32'd1, 1'b1, 32'h0000_0003);
    do_op("sll0", 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0000_0020, 1'b1, 32'hDEAD_BEEF);
    do_op("pass", 2'b10, 3'b110, 32'h1234_5678, 32'd3, 1'b1, 32'h1234_5678);
    do_op("slt", 2'b11, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1);
    do_op("sltu", 2'b11, 3'b011, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0);
    do_op("nor", 2'b00, 3'b011, 32'hF0F0_0000, 32'h0F0F_0000, 1'b1, 32'h0000_FFFF);
`ifdef ALU_MULDIV_EN
    do_op("mul", 2'b01, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
    @(posedge clk); #1;
    chk("mul.single_pulse", 64'(bus.o_valid), 64'd0);
    do_op("mulhu", 2'b01, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    do_op("divu", 2'b01, 3'b010, 32'd100, 32'd7, 1'b1, 32'd14);
    do_op("remu", 2'b01, 3'b011, 32'd100, 32'd7, 1'b1, 32'd2);
    do_op("divu0", 2'b01, 3'b010, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF);
    do_op("remu0", 2'b01, 3'b011, 32'd9, 32'd0, 1'b1, 32'd9);
`else
    do_op("mul_stub", 2'b01, 3'b000, 32'd3, 32'd4, 1'b1, 32'd0);
`endif

    // Reset 10 cycles into a DIVU: no result, outputs cleared.
    do_op("pre_abort", 2'b00, 3'b001, 32'h00FF_0000, 32'h0000_00FF, 1'b1, 32'h00FF_00FF);
    bus.i_valid = 1'b1; bus.i_alufunc = 2'b01; bus.i_opt = 3'b010; bus.i_a = 32'd1000; bus.i_b = 32'd3;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.valid", 64'(bus.o_valid), 64'd0);
    chk("abort.result", 64'(bus.o_result), 64'd0);
    chk("abort.flags", 64'({bus.o_zero, bus.o_ovfl, bus.o_divz}), 64'd0);
    chk("abort.ready", 64'(bus.o_ready), 64'd0);
    rst = 1'b0;
    do_op("post_rst_add", 2'b11, 3'b000, 32'd2, 32'd3, 1'b1, 32'd5);
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      chk("abort.no_late_valid", 64'(bus.o_valid), 64'd0);
    end

    for (int i = 0; i < 60; i++) begin
      rf = 2'($urandom_range(0, 3));
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 40);
      if (rf == 2'b01 && $urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000 | $urandom_range(0, 3);
      do_op("rand", rf, ro, ra, rb, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
